// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and event counters.
// Latency: one cycle from id_* to id_ex_*; stall_if_id is same-cycle combinational.
// Backpressure: a load-use hazard holds PC/IF-ID upstream via stall_if_id and inserts a bubble.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             ex_flush,
    output logic             stall_if_id,
    output logic             id_ex_valid,
    output logic [XLEN-1:0]  id_ex_pc,
    output logic [4:0]       id_ex_rs1,
    output logic [4:0]       id_ex_rs2,
    output logic [4:0]       id_ex_rd,
    output logic [XLEN-1:0]  id_ex_rs1_data,
    output logic [XLEN-1:0]  id_ex_rs2_data,
    output logic [XLEN-1:0]  id_ex_imm,
    output logic [3:0]       id_ex_alu_op,
    output logic             id_ex_alu_src,
    output logic             id_ex_reg_write,
    output logic             id_ex_mem_read,
    output logic             id_ex_mem_write,
    output logic             id_ex_mem_to_reg,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } stage_t;

    stage_t id_stage;
    stage_t stage_q;
    logic   hazard;

    always_comb begin
        id_stage            = '0;
        id_stage.valid      = id_valid;
        id_stage.pc         = id_pc;
        id_stage.rs1        = id_rs1;
        id_stage.rs2        = id_rs2;
        id_stage.rd         = id_rd;
        id_stage.rs1_data   = id_rs1_data;
        id_stage.rs2_data   = id_rs2_data;
        id_stage.imm        = id_imm;
        id_stage.alu_op     = id_alu_op;
        id_stage.alu_src    = id_alu_src;
        id_stage.reg_write  = id_reg_write;
        id_stage.mem_read   = id_mem_read;
        id_stage.mem_write  = id_mem_write;
        id_stage.mem_to_reg = id_mem_to_reg;
    end

    // A load in EX whose rd feeds the ID instruction; x0 never creates a dependency.
    assign hazard = id_valid & stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0)
                  & ((stage_q.rd == id_rs1) | (stage_q.rd == id_rs2));

    // A flush squashes the ID instruction anyway, so holding it upstream would be pointless.
    assign stall_if_id = hazard & ~ex_flush & ~rst;

    // The bubble clears mem_read, so the re-presented instruction never re-triggers the hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (ex_flush) begin
            stage_q <= '0;
            if (flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end else if (hazard) begin
            stage_q <= '0;
            if (stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end else begin
            stage_q <= id_stage;
        end
    end

    assign id_ex_valid      = stage_q.valid;
    assign id_ex_pc         = stage_q.pc;
    assign id_ex_rs1        = stage_q.rs1;
    assign id_ex_rs2        = stage_q.rs2;
    assign id_ex_rd         = stage_q.rd;
    assign id_ex_rs1_data   = stage_q.rs1_data;
    assign id_ex_rs2_data   = stage_q.rs2_data;
    assign id_ex_imm        = stage_q.imm;
    assign id_ex_alu_op     = stage_q.alu_op;
    assign id_ex_alu_src    = stage_q.alu_src;
    assign id_ex_reg_write  = stage_q.reg_write;
    assign id_ex_mem_read   = stage_q.mem_read;
    assign id_ex_mem_write  = stage_q.mem_write;
    assign id_ex_mem_to_reg = stage_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: pass-through, load-use stalls, flush priority, saturation, reset.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        ex_flush;

    logic        stall_if_id, id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
    logic [15:0] stall_count, flush_count;

    logic        s_stall_if_id, s_valid;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [3:0]  s_alu_op;
    logic        s_alu_src, s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg;
    logic [1:0]  s_stall_count, s_flush_count;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .ex_flush(ex_flush), .stall_if_id(stall_if_id), .id_ex_valid(id_ex_valid),
        .id_ex_pc(id_ex_pc), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    id_ex_stage_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .ex_flush(ex_flush), .stall_if_id(s_stall_if_id), .id_ex_valid(s_valid),
        .id_ex_pc(s_pc), .id_ex_rs1(s_rs1), .id_ex_rs2(s_rs2), .id_ex_rd(s_rd),
        .id_ex_rs1_data(s_rs1_data), .id_ex_rs2_data(s_rs2_data), .id_ex_imm(s_imm),
        .id_ex_alu_op(s_alu_op), .id_ex_alu_src(s_alu_src),
        .id_ex_reg_write(s_reg_write), .id_ex_mem_read(s_mem_read),
        .id_ex_mem_write(s_mem_write), .id_ex_mem_to_reg(s_mem_to_reg),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one ID instruction; mr=load, rw=writes rd.
    task automatic put(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                       input logic [3:0] op, input logic rw, input logic mr);
        id_valid      = v;
        id_pc         = pc;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_rd         = rd;
        id_rs1_data   = pc ^ 32'hA5A5_0000;
        id_rs2_data   = pc ^ 32'h0000_5A5A;
        id_imm        = imm;
        id_alu_op     = op;
        id_alu_src    = mr;
        id_reg_write  = rw;
        id_mem_read   = mr;
        id_mem_write  = 1'b0;
        id_mem_to_reg = mr;
    endtask

    // Inputs change 1 time unit after the rising edge; registered outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic comb_point();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ex_flush = 1'b0;
        put(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 4'($urandom), 1'b1, 1'b1);
        ex_flush = 1'($urandom);

        // Reset held two cycles with arbitrary inputs.
        tick();
        tick();
        chk("rst_valid", 64'(id_ex_valid), 64'd0);
        chk("rst_rd", 64'(id_ex_rd), 64'd0);
        chk("rst_pc", 64'(id_ex_pc), 64'd0);
        chk("rst_mem_read", 64'(id_ex_mem_read), 64'd0);
        chk("rst_stall_if_id", 64'(stall_if_id), 64'd0);
        chk("rst_stall_count", 64'(stall_count), 64'd0);
        chk("rst_flush_count", 64'(flush_count), 64'd0);

        // Pass-through of an ALU instruction.
        rst = 1'b0;
        ex_flush = 1'b0;
        put(1'b1, 32'h100, 5'd3, 5'd4, 5'd5, 32'h10, 4'd3, 1'b1, 1'b0);
        comb_point();
        chk("pt_stall", 64'(stall_if_id), 64'd0);
        tick();
        chk("pt_rd", 64'(id_ex_rd), 64'd5);
        chk("pt_imm", 64'(id_ex_imm), 64'h10);
        chk("pt_valid", 64'(id_ex_valid), 64'd1);
        chk("pt_pc", 64'(id_ex_pc), 64'h100);
        chk("pt_rs1_data", 64'(id_ex_rs1_data), 64'hA5A5_0100);
        chk("pt_alu_op", 64'(id_ex_alu_op), 64'd3);
        chk("pt_reg_write", 64'(id_ex_reg_write), 64'd1);

        // Load-use through rs2: lw x5, then add x7 = x6 + x5.
        put(1'b1, 32'h104, 5'd1, 5'd0, 5'd5, 32'h8, 4'd0, 1'b1, 1'b1);
        comb_point();
        chk("lw_no_stall", 64'(stall_if_id), 64'd0);
        tick();
        chk("lw_mem_read", 64'(id_ex_mem_read), 64'd1);
        put(1'b1, 32'h108, 5'd6, 5'd5, 5'd7, 32'h0, 4'd1, 1'b1, 1'b0);
        comb_point();
        chk("lu_stall", 64'(stall_if_id), 64'd1);
        tick();
        chk("lu_bubble_valid", 64'(id_ex_valid), 64'd0);
        chk("lu_bubble_rd", 64'(id_ex_rd), 64'd0);
        chk("lu_bubble_pc", 64'(id_ex_pc), 64'd0);
        chk("lu_bubble_mem_read", 64'(id_ex_mem_read), 64'd0);
        chk("lu_stall_count", 64'(stall_count), 64'd1);
        comb_point();
        chk("lu_stall_released", 64'(stall_if_id), 64'd0);
        tick();
        chk("lu_add_rd", 64'(id_ex_rd), 64'd7);
        chk("lu_add_rs2", 64'(id_ex_rs2), 64'd5);
        chk("lu_add_valid", 64'(id_ex_valid), 64'd1);
        chk("lu_stall_count_hold", 64'(stall_count), 64'd1);

        // Back-to-back dependent loads through rs1: lw x8; lw x9,(x8); add x10 = x9 + x0.
        put(1'b1, 32'h10C, 5'd2, 5'd0, 5'd8, 32'h4, 4'd0, 1'b1, 1'b1);
        tick();
        put(1'b1, 32'h110, 5'd8, 5'd0, 5'd9, 32'h0, 4'd0, 1'b1, 1'b1);
        comb_point();
        chk("b2b_stall1", 64'(stall_if_id), 64'd1);
        tick();
        chk("b2b_bubble1", 64'(id_ex_valid), 64'd0);
        tick();
        chk("b2b_lw9_rd", 64'(id_ex_rd), 64'd9);
        put(1'b1, 32'h114, 5'd9, 5'd0, 5'd10, 32'h0, 4'd2, 1'b1, 1'b0);
        comb_point();
        chk("b2b_stall2", 64'(stall_if_id), 64'd1);
        tick();
        tick();
        chk("b2b_add_rd", 64'(id_ex_rd), 64'd10);
        chk("b2b_stall_count", 64'(stall_count), 64'd3);
        chk("sat_stall_count", 64'(s_stall_count), 64'd3);

        // Load into x0 never stalls.
        put(1'b1, 32'h118, 5'd1, 5'd0, 5'd0, 32'h0, 4'd0, 1'b1, 1'b1);
        tick();
        put(1'b1, 32'h11C, 5'd0, 5'd0, 5'd11, 32'h0, 4'd1, 1'b1, 1'b0);
        comb_point();
        chk("x0_no_stall", 64'(stall_if_id), 64'd0);
        tick();
        chk("x0_valid", 64'(id_ex_valid), 64'd1);
        chk("x0_stall_count", 64'(stall_count), 64'd3);

        // Invalid ID slot does not stall behind a load.
        put(1'b1, 32'h120, 5'd1, 5'd0, 5'd12, 32'h0, 4'd0, 1'b1, 1'b1);
        tick();
        put(1'b0, 32'h124, 5'd12, 5'd12, 5'd13, 32'h0, 4'd1, 1'b1, 1'b0);
        comb_point();
        chk("inv_no_stall", 64'(stall_if_id), 64'd0);
        tick();
        chk("inv_valid", 64'(id_ex_valid), 64'd0);
        chk("inv_rd", 64'(id_ex_rd), 64'd13);

        // Flush in a hazard cycle: flush wins.
        put(1'b1, 32'h128, 5'd1, 5'd0, 5'd14, 32'h0, 4'd0, 1'b1, 1'b1);
        tick();
        put(1'b1, 32'h12C, 5'd14, 5'd3, 5'd15, 32'h0, 4'd1, 1'b1, 1'b0);
        ex_flush = 1'b1;
        comb_point();
        chk("fh_stall", 64'(stall_if_id), 64'd0);
        tick();
        chk("fh_valid", 64'(id_ex_valid), 64'd0);
        chk("fh_rd", 64'(id_ex_rd), 64'd0);
        chk("fh_flush_count", 64'(flush_count), 64'd1);
        chk("fh_stall_count", 64'(stall_count), 64'd3);

        // Four more flushes: wide counter reaches 5, 2-bit counter sticks at 3.
        repeat (4) tick();
        chk("fl_flush_count", 64'(flush_count), 64'd5);
        chk("sat_flush_count", 64'(s_flush_count), 64'd3);
        ex_flush = 1'b0;

        // Reset during a pending stall discards everything.
        put(1'b1, 32'h130, 5'd1, 5'd0, 5'd16, 32'h0, 4'd0, 1'b1, 1'b1);
        tick();
        put(1'b1, 32'h134, 5'd16, 5'd0, 5'd17, 32'h0, 4'd1, 1'b1, 1'b0);
        comb_point();
        chk("mr_stall_before", 64'(stall_if_id), 64'd1);
        rst = 1'b1;
        comb_point();
        chk("mr_stall_in_rst", 64'(stall_if_id), 64'd0);
        tick();
        chk("mr_valid", 64'(id_ex_valid), 64'd0);
        chk("mr_mem_read", 64'(id_ex_mem_read), 64'd0);
        chk("mr_stall_count", 64'(stall_count), 64'd0);
        chk("mr_flush_count", 64'(flush_count), 64'd0);
        rst = 1'b0;
        comb_point();
        chk("mr_resume_no_stall", 64'(stall_if_id), 64'd0);
        tick();
        chk("mr_resume_rd", 64'(id_ex_rd), 64'd17);
        chk("mr_resume_valid", 64'(id_ex_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
